// File: rtl/col_fifo_bank.sv
// col_fifo_bank: bank of COL_MAX_SIZE independent synchronous FIFOs sharing one write bus.
// Optional feature macro: COL_FIFO_FWFT_EN selects first-word-fall-through output per channel;
// when it is undefined each channel uses a registered one-cycle read latency.
// Ports:
//   i_user_clk     rising-edge clock for all logic
//   i_user_rst     asynchronous reset, active-low
//   i_clr          synchronous flush of every channel; strobes ignored that cycle
//   i_din          shared write data
//   i_wr_en        per-channel write strobes (multi-hot allowed)
//   i_rd_en        per-channel read strobes
//   o_full         channel holds DEPTH words
//   o_almost_full  channel level >= AFULL_THRESH
//   o_empty        no readable word in channel
//   o_dout         channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   o_level        channel i at [i*(DEPTH_LOG2+1) +: DEPTH_LOG2+1]
//   o_overflow     sticky: write attempted while full
//   o_underflow    sticky: read attempted while empty
module col_fifo_bank #(
    parameter int DATA_WIDTH   = 128,
    parameter int COL_MAX_SIZE = 4,
    parameter int DEPTH_LOG2   = 9,
    parameter int AFULL_THRESH = 480
) (
    input  logic                                  i_user_clk,
    input  logic                                  i_user_rst,
    input  logic                                  i_clr,
    input  logic [DATA_WIDTH-1:0]                 i_din,
    input  logic [COL_MAX_SIZE-1:0]               i_wr_en,
    output logic [COL_MAX_SIZE-1:0]               o_full,
    output logic [COL_MAX_SIZE-1:0]               o_almost_full,
    input  logic [COL_MAX_SIZE-1:0]               i_rd_en,
    output logic [COL_MAX_SIZE*DATA_WIDTH-1:0]    o_dout,
    output logic [COL_MAX_SIZE-1:0]               o_empty,
    output logic [COL_MAX_SIZE*(DEPTH_LOG2+1)-1:0] o_level,
    output logic [COL_MAX_SIZE-1:0]               o_overflow,
    output logic [COL_MAX_SIZE-1:0]               o_underflow
);
    localparam int LW = DEPTH_LOG2 + 1;
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [LW-1:0] AF_LVL = LW'(AFULL_THRESH);

    for (genvar g = 0; g < COL_MAX_SIZE; g++) begin : g_ch
        logic [DATA_WIDTH-1:0] r_mem [DEPTH];
        logic [DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
        logic [LW-1:0]         r_level;
        logic [DATA_WIDTH-1:0] r_dout;
        logic                  r_ovf, r_udf;
        logic                  w_full, w_empty, w_wr, w_rd, w_pop;

        assign w_full = r_level == FULL_LVL;
`ifdef COL_FIFO_FWFT_EN
        logic r_dv;
        // level includes the output-stage word, so memory holds r_level - r_dv words;
        // refill the output stage whenever it is free or being popped this cycle
        assign w_empty = ~r_dv;
        assign w_pop   = (r_level > LW'(r_dv)) & (~r_dv | w_rd);
        always_ff @(posedge i_user_clk or negedge i_user_rst) begin
            if (!i_user_rst)
                r_dv <= 1'b0;
            else if (i_clr)
                r_dv <= 1'b0;
            else if (w_pop)
                r_dv <= 1'b1;
            else if (w_rd)
                r_dv <= 1'b0;
        end
`else
        assign w_empty = r_level == '0;
        assign w_pop   = w_rd;
`endif
        assign w_wr = i_wr_en[g] & ~w_full;
        assign w_rd = i_rd_en[g] & ~w_empty;

        always_ff @(posedge i_user_clk) begin
            if (w_wr && !i_clr)
                r_mem[r_wr_ptr] <= i_din;
        end

        always_ff @(posedge i_user_clk or negedge i_user_rst) begin
            if (!i_user_rst) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_level  <= '0;
                r_dout   <= '0;
                r_ovf    <= 1'b0;
                r_udf    <= 1'b0;
            end else if (i_clr) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_level  <= '0;
                r_dout   <= '0;
                r_ovf    <= 1'b0;
                r_udf    <= 1'b0;
            end else begin
                if (w_wr)
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                    r_dout   <= r_mem[r_rd_ptr];
                end
                r_level <= r_level + LW'(w_wr) - LW'(w_rd);
                r_ovf   <= r_ovf | (i_wr_en[g] & w_full);
                r_udf   <= r_udf | (i_rd_en[g] & w_empty);
            end
        end

        assign o_full[g]                            = w_full;
        assign o_almost_full[g]                     = r_level >= AF_LVL;
        assign o_empty[g]                           = w_empty;
        assign o_dout[g*DATA_WIDTH +: DATA_WIDTH]   = r_dout;
        assign o_level[g*LW +: LW]                  = r_level;
        assign o_overflow[g]                        = r_ovf;
        assign o_underflow[g]                       = r_udf;
    end
endmodule

// File: tb/tb_col_fifo_bank.sv
// tb_col_fifo_bank: directed self-checking bench for col_fifo_bank with default parameters.
module tb_col_fifo_bank;
    localparam int DW = 128;
    localparam int N = 4;
    localparam int LW = 10;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            clr = 1'b0;
    logic [DW-1:0]   din = '0;
    logic [N-1:0]    wr_en = '0;
    logic [N-1:0]    rd_en = '0;
    logic [N-1:0]    full, almost_full, empty, overflow, underflow;
    logic [N*DW-1:0] dout;
    logic [N*LW-1:0] level;
    int              n_chk = 0;
    int              n_err = 0;

    col_fifo_bank dut (
        .i_user_clk   (clk),
        .i_user_rst   (rst_n),
        .i_clr        (clr),
        .i_din        (din),
        .i_wr_en      (wr_en),
        .o_full       (full),
        .o_almost_full(almost_full),
        .i_rd_en      (rd_en),
        .o_dout       (dout),
        .o_empty      (empty),
        .o_level      (level),
        .o_overflow   (overflow),
        .o_underflow  (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LW-1:0] lvl(input int i);
        return level[i*LW +: LW];
    endfunction

    function automatic logic [DW-1:0] dat(input int i);
        return dout[i*DW +: DW];
    endfunction

    initial begin
        tick;
        tick;
        rst_n = 1'b1;
        // test 1: traffic then asynchronous reset
        wr_en = 4'b1001;
        din = 128'h11;
        tick;
        tick;
        wr_en = 4'b0001;
        tick;
        wr_en = '0;
        chk("t1_lvl0", lvl(0), 3);
        chk("t1_lvl3", lvl(3), 2);
        chk("t1_empty", empty, 4'b0110);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_rst_empty", empty, 4'hF);
        chk("t1_rst_full", full, 0);
        chk("t1_rst_level", level, 0);
        chk("t1_rst_flags", {overflow, underflow, almost_full}, 0);
        chk("t1_rst_dout", dout[DW-1:0], 0);
        repeat (3) tick;
        rst_n = 1'b1;
        chk("t1_hold_level", level, 0);
        // test 2: fill channel 2
        wr_en = 4'b0100;
        for (int k = 0; k < 512; k++) begin
            din = DW'(k);
            tick;
            if (k == 478) chk("t2_af_479", almost_full[2], 0);
            if (k == 479) chk("t2_af_480", almost_full[2], 1);
            if (k == 510) chk("t2_full_511", full[2], 0);
        end
        chk("t2_full", full[2], 1);
        chk("t2_lvl512", lvl(2), 512);
        chk("t2_no_ovf", overflow[2], 0);
        din = 128'h3e7;
        tick;
        wr_en = '0;
        chk("t2_ovf", overflow[2], 1);
        chk("t2_lvl_hold", lvl(2), 512);
        chk("t2_other_empty", empty & 4'b1011, 4'b1011);
        // test 3: drain channel 2 in order
        for (int k = 0; k < 512; k++) begin
`ifdef COL_FIFO_FWFT_EN
            chk("t3_dout", dat(2), DW'(k));
            rd_en = 4'b0100;
            tick;
`else
            rd_en = 4'b0100;
            tick;
            chk("t3_dout", dat(2), DW'(k));
`endif
        end
        chk("t3_empty", empty[2], 1);
        chk("t3_no_udf", underflow[2], 0);
        tick;
        rd_en = '0;
        chk("t3_udf", underflow[2], 1);
        chk("t3_dout_hold", dat(2), 511);
        chk("t3_lvl0", lvl(2), 0);
        // test 4: multi-hot write
        wr_en = 4'b1011;
        din = {16{8'hA5}};
        tick;
        wr_en = '0;
        chk("t4_lvl0", lvl(0), 1);
        chk("t4_lvl1", lvl(1), 1);
        chk("t4_lvl2", lvl(2), 0);
        chk("t4_lvl3", lvl(3), 1);
        tick;
        // test 5: pop channel 1 empty, fill channel 0, then read+write on both
        rd_en = 4'b0010;
        tick;
        rd_en = '0;
        chk("t5_ch1_empty", empty[1], 1);
        chk("t5_ch1_dout", dat(1), {16{8'hA5}});
        wr_en = 4'b0001;
        for (int k = 0; k < 511; k++) begin
            din = DW'(k + 1000);
            tick;
        end
        chk("t5_full0", full[0], 1);
        wr_en = 4'b0011;
        rd_en = 4'b0011;
        din = 128'h77;
        tick;
        wr_en = '0;
        rd_en = '0;
        chk("t5_lvl0", lvl(0), 511);
        chk("t5_ovf0", overflow[0], 1);
        chk("t5_lvl1", lvl(1), 1);
        chk("t5_udf1", underflow[1], 1);
        chk("t5_flags_other", {underflow[0], overflow[1]}, 0);
        // test 6: flush with channel 0 at level 100
        rd_en = 4'b0001;
        repeat (411) tick;
        rd_en = '0;
        chk("t6_lvl100", lvl(0), 100);
        clr = 1'b1;
        wr_en = 4'b1111;
        rd_en = 4'b1111;
        tick;
        clr = 1'b0;
        wr_en = '0;
        rd_en = '0;
        chk("t6_level", level, 0);
        chk("t6_empty", empty, 4'hF);
        chk("t6_flags", {overflow, underflow, almost_full, full}, 0);
        chk("t6_dout", dat(0), 0);
        wr_en = 4'b0001;
        din = 128'h7;
        tick;
        wr_en = '0;
        chk("t6_lvl1", lvl(0), 1);
`ifdef COL_FIFO_FWFT_EN
        chk("t6_fwft_empty_n1", empty[0], 1);
        tick;
        chk("t6_fwft_empty_n2", empty[0], 0);
        chk("t6_fwft_dout", dat(0), 128'h7);
`else
        chk("t6_empty_n1", empty[0], 0);
        rd_en = 4'b0001;
        tick;
        rd_en = '0;
        chk("t6_dout_n2", dat(0), 128'h7);
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
